// File: rtl/lcd_capture_pkg.sv
// Shared definitions for the LCD capture block: AHB field widths, address map,
// register indices, STATUS bit positions and capture FSM encoding.
package lcd_capture_pkg;

  localparam int unsigned W_TRANS = 2;
  localparam int unsigned W_BURST = 3;
  localparam int unsigned W_SIZE  = 3;
  localparam int unsigned W_RESP  = 2;

  localparam logic [W_RESP-1:0] RESP_OKAY = 2'b00;

  localparam logic [31:0] RISCV_MASK_LCD_CAPTURE_IMG   = 32'hFF00_0000;
  localparam logic [31:0] RISCV_LCD_CAPTURE_IMG_OFFSET = 32'h1000_0000;

  localparam logic [3:0] REG_CTRL       = 4'd0;
  localparam logic [3:0] REG_STATUS     = 4'd1;
  localparam logic [3:0] REG_PAIR_COUNT = 4'd2;
  localparam logic [3:0] REG_CHECKSUM   = 4'd3;
  localparam logic [3:0] REG_WIDTH      = 4'd4;
  localparam logic [3:0] REG_HEIGHT     = 4'd5;
  localparam logic [3:0] REG_LINE_COUNT = 4'd6;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_DONE    = 1;
  localparam int unsigned STAT_OVERRUN = 2;

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} cap_state_e;

endpackage

// File: rtl/lcd_capture_buffer.sv
// Simple dual-port capture RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
module lcd_capture_buffer #(
  parameter int unsigned Depth = 16,
  parameter int unsigned DataW = 48,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd_capture_if.sv
// Captures one frame of the dual-pixel RGB stream into a buffer, with checksum and
// counters, and exposes status, counters and pixels through an AHB-Lite slave.
module lcd_capture_if
  import lcd_capture_pkg::*;
#(
  parameter int unsigned W_ADDR    = 32,
  parameter int unsigned W_DATA    = 32,
  parameter int unsigned W_WB_DATA = 2,
  parameter int unsigned IMG_PIX_W = 8,
  parameter int unsigned WIDTH     = 768,
  parameter int unsigned HEIGHT    = 512,
  parameter int unsigned N_PAIR    = WIDTH * HEIGHT / 2,
  parameter int unsigned W_PAIR    = $clog2(N_PAIR)
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 sl_HSEL,
  input  logic                 sl_HREADY,
  input  logic                 sl_HWRITE,
  input  logic [W_TRANS-1:0]   sl_HTRANS,
  input  logic [W_BURST-1:0]   sl_HBURST,
  input  logic [W_SIZE-1:0]    sl_HSIZE,
  input  logic [W_ADDR-1:0]    sl_HADDR,
  input  logic [W_DATA-1:0]    sl_HWDATA,
  output logic                 out_sl_HREADY,
  output logic [W_RESP-1:0]    out_sl_HRESP,
  output logic [W_DATA-1:0]    out_sl_HRDATA,
  input  logic                 in_valid,
  input  logic [IMG_PIX_W-1:0] in_r0,
  input  logic [IMG_PIX_W-1:0] in_g0,
  input  logic [IMG_PIX_W-1:0] in_b0,
  input  logic [IMG_PIX_W-1:0] in_r1,
  input  logic [IMG_PIX_W-1:0] in_g1,
  input  logic [IMG_PIX_W-1:0] in_b1
);

  localparam int unsigned W_PIX = 3 * IMG_PIX_W;

  // AHB address/data phase tracking
  logic              accept, img_hit;
  logic              reg_wr_q, reg_rd_q, rd_wait_q, img_rd_q, pix_sel_q;
  logic [3:0]        idx_q;
  logic [W_PAIR-1:0] pair_addr_q;

  assign accept  = sl_HSEL && sl_HREADY && sl_HTRANS[1] && !rd_wait_q;
  assign img_hit = (sl_HADDR & W_ADDR'(RISCV_MASK_LCD_CAPTURE_IMG))
                   == W_ADDR'(RISCV_LCD_CAPTURE_IMG_OFFSET);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      rd_wait_q   <= 1'b0;
      img_rd_q    <= 1'b0;
      pix_sel_q   <= 1'b0;
      idx_q       <= '0;
      pair_addr_q <= '0;
    end else begin
      reg_wr_q  <= accept && sl_HWRITE && !img_hit;
      reg_rd_q  <= accept && !sl_HWRITE && !img_hit;
      rd_wait_q <= accept && !sl_HWRITE && img_hit;
      img_rd_q  <= rd_wait_q;
      if (accept) begin
        idx_q       <= sl_HADDR[W_WB_DATA+3:W_WB_DATA];
        pix_sel_q   <= sl_HADDR[W_WB_DATA];
        pair_addr_q <= sl_HADDR[W_PAIR+W_WB_DATA:W_WB_DATA+1];
      end
    end
  end

  logic ctrl_wr, arm, clr;
  assign ctrl_wr = reg_wr_q && (idx_q == REG_CTRL);
  assign arm     = ctrl_wr && sl_HWDATA[0];
  assign clr     = ctrl_wr && sl_HWDATA[1];

  // Capture state
  cap_state_e  state_q, state_d;
  logic [11:0] width_q, height_q, col_q, col_d;
  logic [23:0] target_q, target_d, pair_cnt_q, pair_cnt_d, area;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic [31:0] cksum_q, cksum_d, beat_sum;
  logic        done_q, done_d, ovr_q, ovr_d, buf_we;

  assign area     = {12'b0, width_q} * {12'b0, height_q};
  assign beat_sum = 32'(in_r0) + 32'(in_g0) + 32'(in_b0)
                  + 32'(in_r1) + 32'(in_g1) + 32'(in_b1);

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    pair_cnt_d = pair_cnt_q;
    col_d      = col_q;
    line_cnt_d = line_cnt_q;
    cksum_d    = cksum_q;
    done_d     = done_q;
    ovr_d      = ovr_q;
    buf_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
      end
      StArmed, StCapture: begin
        if (in_valid) begin
          buf_we  = pair_cnt_q < 24'(N_PAIR);
          cksum_d = cksum_q + beat_sum;
          if (pair_cnt_q < target_q) pair_cnt_d = pair_cnt_q + 24'd1;
          if (col_q == width_q - 12'd2) begin
            col_d      = '0;
            line_cnt_d = line_cnt_q + 16'd1;
          end else begin
            col_d = col_q + 12'd2;
          end
          if (pair_cnt_q == target_q - 24'd1) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StCapture;
          end
        end
      end
      StDone: begin
        if (in_valid) ovr_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (clr) begin
      done_d = 1'b0;
      ovr_d  = 1'b0;
    end
    // Arming restarts from any state and drops a beat arriving in the same cycle
    if (arm) begin
      state_d    = StArmed;
      target_d   = {1'b0, area[23:1]};
      pair_cnt_d = '0;
      col_d      = '0;
      line_cnt_d = '0;
      cksum_d    = '0;
      done_d     = 1'b0;
      ovr_d      = 1'b0;
      buf_we     = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= StIdle;
      target_q   <= '0;
      pair_cnt_q <= '0;
      col_q      <= '0;
      line_cnt_q <= '0;
      cksum_q    <= '0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      width_q    <= 12'(WIDTH);
      height_q   <= 12'(HEIGHT);
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      pair_cnt_q <= pair_cnt_d;
      col_q      <= col_d;
      line_cnt_q <= line_cnt_d;
      cksum_q    <= cksum_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      if (reg_wr_q && idx_q == REG_WIDTH)  width_q  <= sl_HWDATA[11:0];
      if (reg_wr_q && idx_q == REG_HEIGHT) height_q <= sl_HWDATA[11:0];
    end
  end

  logic [6*IMG_PIX_W-1:0] buf_rdata;

  lcd_capture_buffer #(
    .Depth (N_PAIR),
    .DataW (6 * IMG_PIX_W),
    .AddrW (W_PAIR)
  ) u_buffer (
    .clk_i   (HCLK),
    .we_i    (buf_we),
    .waddr_i (pair_cnt_q[W_PAIR-1:0]),
    .wdata_i ({in_r1, in_g1, in_b1, in_r0, in_g0, in_b0}),
    .re_i    (rd_wait_q),
    .raddr_i (pair_addr_q),
    .rdata_o (buf_rdata)
  );

  logic busy;
  assign busy = (state_q == StArmed) || (state_q == StCapture);

  always_comb begin
    out_sl_HRDATA = '0;
    if (img_rd_q) begin
      out_sl_HRDATA = W_DATA'(pix_sel_q ? buf_rdata[2*W_PIX-1:W_PIX] : buf_rdata[W_PIX-1:0]);
    end else if (reg_rd_q) begin
      case (idx_q)
        REG_STATUS: begin
          out_sl_HRDATA[STAT_BUSY]    = busy;
          out_sl_HRDATA[STAT_DONE]    = done_q;
          out_sl_HRDATA[STAT_OVERRUN] = ovr_q;
        end
        REG_PAIR_COUNT: out_sl_HRDATA = W_DATA'(pair_cnt_q);
        REG_CHECKSUM:   out_sl_HRDATA = W_DATA'(cksum_q);
        REG_WIDTH:      out_sl_HRDATA = W_DATA'(width_q);
        REG_HEIGHT:     out_sl_HRDATA = W_DATA'(height_q);
        REG_LINE_COUNT: out_sl_HRDATA = W_DATA'(line_cnt_q);
        default:        out_sl_HRDATA = '0;
      endcase
    end
  end

  assign out_sl_HREADY = !rd_wait_q;
  assign out_sl_HRESP  = RESP_OKAY;

  logic unused_in;
  assign unused_in = ^{sl_HTRANS[0], sl_HBURST, sl_HSIZE, sl_HWDATA[W_DATA-1:12]};

endmodule

// File: tb/tb_lcd_capture_if.sv
// Bench for lcd_capture_if on an 8x4 frame: AHB register/image reads and a
// frame-level reference model of the capture behaviour.
module tb_lcd_capture_if;
  import lcd_capture_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        sl_HSEL = 1'b0, sl_HWRITE = 1'b0;
  logic [1:0]  sl_HTRANS = 2'b00;
  logic [2:0]  sl_HBURST = 3'b000, sl_HSIZE = 3'b010;
  logic [31:0] sl_HADDR = '0, sl_HWDATA = '0;
  logic        out_sl_HREADY;
  logic [1:0]  out_sl_HRESP;
  logic [31:0] out_sl_HRDATA;
  logic        in_valid = 1'b0;
  logic [7:0]  in_r0 = '0, in_g0 = '0, in_b0 = '0, in_r1 = '0, in_g1 = '0, in_b1 = '0;

  lcd_capture_if #(
    .WIDTH  (8),
    .HEIGHT (4)
  ) dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .sl_HSEL       (sl_HSEL),
    .sl_HREADY     (out_sl_HREADY),
    .sl_HWRITE     (sl_HWRITE),
    .sl_HTRANS     (sl_HTRANS),
    .sl_HBURST     (sl_HBURST),
    .sl_HSIZE      (sl_HSIZE),
    .sl_HADDR      (sl_HADDR),
    .sl_HWDATA     (sl_HWDATA),
    .out_sl_HREADY (out_sl_HREADY),
    .out_sl_HRESP  (out_sl_HRESP),
    .out_sl_HRDATA (out_sl_HRDATA),
    .in_valid      (in_valid),
    .in_r0         (in_r0),
    .in_g0         (in_g0),
    .in_b0         (in_b0),
    .in_r1         (in_r1),
    .in_g1         (in_g1),
    .in_b1         (in_b1)
  );

  always #5 HCLK = ~HCLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 idle, 1 capturing (armed or mid-frame), 2 frame complete
  int          m_state, m_cnt, m_target, m_w, m_h;
  bit          m_done, m_ovr;
  logic [31:0] m_ck;
  logic [47:0] m_mem [16];

  function automatic void m_reset();
    m_state = 0; m_cnt = 0; m_target = 0; m_ck = 0; m_done = 0; m_ovr = 0;
    m_w = 8; m_h = 4;
  endfunction

  function automatic void m_arm();
    m_state = 1; m_cnt = 0; m_ck = 0; m_done = 0; m_ovr = 0;
    m_target = m_w * m_h / 2;
  endfunction

  function automatic void m_beat(logic [47:0] p);
    if (m_state == 1) begin
      if (m_cnt < 16) m_mem[m_cnt] = p;
      m_cnt++;
      for (int i = 0; i < 6; i++) m_ck += 32'((p >> (8 * i)) & 48'hFF);
      if (m_cnt == m_target) begin
        m_state = 2;
        m_done  = 1;
      end
    end else if (m_state == 2) begin
      m_ovr = 1;
    end
  endfunction

  function automatic logic [31:0] m_status();
    return {29'b0, m_ovr, m_done, m_state == 1};
  endfunction

  function automatic logic [31:0] m_lines();
    return 32'(m_cnt / (m_w / 2));
  endfunction

  function automatic logic [31:0] m_pixel(int word);
    logic [47:0] p;
    p = m_mem[word / 2];
    return (word % 2) ? {8'h0, p[47:24]} : {8'h0, p[23:0]};
  endfunction

  // All tasks start and end 1 time unit after a rising edge
  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    sl_HSEL = 1'b1; sl_HTRANS = 2'b10; sl_HWRITE = 1'b1; sl_HADDR = addr;
    @(posedge HCLK); #1;
    sl_HSEL = 1'b0; sl_HTRANS = 2'b00; sl_HWRITE = 1'b0; sl_HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data, output int waits);
    sl_HSEL = 1'b1; sl_HTRANS = 2'b10; sl_HWRITE = 1'b0; sl_HADDR = addr;
    @(posedge HCLK); #1;
    sl_HSEL = 1'b0; sl_HTRANS = 2'b00;
    waits = 0;
    while (!out_sl_HREADY && waits < 8) begin
      @(posedge HCLK); #1;
      waits++;
    end
    data = out_sl_HRDATA;
    @(posedge HCLK); #1;
  endtask

  function automatic logic [31:0] img_addr(int word);
    return RISCV_LCD_CAPTURE_IMG_OFFSET + 32'(word * 4);
  endfunction

  // mode 0: components = beat index, 1: all 0xFF, 2: random
  task automatic send_beats(input int n, input int gap, input int mode);
    logic [47:0] p;
    for (int k = 0; k < n; k++) begin
      case (mode)
        0:       p = {6{8'(k)}};
        1:       p = {6{8'hFF}};
        default: p = {$urandom, $urandom};
      endcase
      {in_r1, in_g1, in_b1, in_r0, in_g0, in_b0} = p;
      in_valid = 1'b1;
      @(posedge HCLK);
      m_beat(p);
      #1;
      in_valid = 1'b0;
      for (int g = 0; g < ((gap < 0) ? int'($urandom_range(0, 2)) : gap); g++) begin
        @(posedge HCLK); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic arm();
    ahb_write(32'(REG_CTRL) * 4, 32'h1);
    m_arm();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int w;
    logic [31:0] exp [4] = '{32'd0, 32'd0, 32'd8, 32'd4};
    logic [3:0]  idx [4] = '{REG_STATUS, REG_PAIR_COUNT, REG_WIDTH, REG_HEIGHT};
    n_tests += 2;
    if (out_sl_HREADY !== 1'b1) begin
      $display("FAIL reset_hready: got %b expected 1", out_sl_HREADY); n_fail++;
    end
    if (out_sl_HRDATA !== 32'h0) begin
      $display("FAIL reset_hrdata: got %h expected 0", out_sl_HRDATA); n_fail++;
    end
    for (int i = 0; i < 4; i++) begin
      ahb_read(32'(idx[i]) * 4, d, w);
      n_tests++;
      if (d !== exp[i] || w != 0) begin
        $display("FAIL reset_reg%0d: got %h waits %0d expected %h waits 0", idx[i], d, w, exp[i]);
        n_fail++;
      end
    end
  endtask

  task automatic check_regs(input string name);
    logic [31:0] d;
    int w;
    logic [3:0]  idx [4] = '{REG_STATUS, REG_PAIR_COUNT, REG_CHECKSUM, REG_LINE_COUNT};
    logic [31:0] exp [4];
    exp = '{m_status(), 32'(m_cnt), m_ck, m_lines()};
    for (int i = 0; i < 4; i++) begin
      ahb_read(32'(idx[i]) * 4, d, w);
      n_tests++;
      if (d !== exp[i]) begin
        $display("FAIL %s_reg%0d: got %h expected %h", name, idx[i], d, exp[i]); n_fail++;
      end
    end
  endtask

  task automatic test_capture();
    logic [31:0] d;
    int w;
    arm();
    send_beats(16, 0, 0);
    check_regs("capture");
    ahb_read(32'(REG_CHECKSUM) * 4, d, w);
    n_tests++;
    if (d !== 32'd720) begin
      $display("FAIL capture_checksum_const: got %0d expected 720", d); n_fail++;
    end
  endtask

  task automatic test_img_read();
    logic [31:0] d;
    int w;
    ahb_read(img_addr(5), d, w);
    n_tests++;
    if (d !== 32'h0002_0202 || w != 1) begin
      $display("FAIL img_word5: got %h waits %0d expected 00020202 waits 1", d, w); n_fail++;
    end
    for (int word = 0; word < 32; word += 7) begin
      ahb_read(img_addr(word), d, w);
      n_tests++;
      if (d !== m_pixel(word) || w != 1) begin
        $display("FAIL img_word%0d: got %h waits %0d expected %h waits 1", word, d, w,
                 m_pixel(word));
        n_fail++;
      end
    end
    ahb_write(img_addr(4), 32'hDEAD_BEEF);
    ahb_read(img_addr(4), d, w);
    n_tests++;
    if (d !== m_pixel(4)) begin
      $display("FAIL img_write_ignored: got %h expected %h", d, m_pixel(4)); n_fail++;
    end
  endtask

  task automatic test_gaps_overrun();
    logic [31:0] d;
    int w;
    arm();
    send_beats(16, 1, 0);
    send_beats(2, 0, 1);
    check_regs("overrun");
    ahb_write(32'(REG_CTRL) * 4, 32'h2);
    m_done = 0; m_ovr = 0;
    ahb_read(32'(REG_STATUS) * 4, d, w);
    n_tests++;
    if (d !== 32'h0) begin
      $display("FAIL clear_status: got %h expected 0", d); n_fail++;
    end
  endtask

  task automatic test_rearm();
    logic [31:0] d;
    int w;
    arm();
    send_beats(7, 0, 2);
    arm();
    send_beats(16, 0, 1);
    check_regs("rearm");
    ahb_read(32'(REG_CHECKSUM) * 4, d, w);
    n_tests++;
    if (d !== 32'd24480) begin
      $display("FAIL rearm_checksum_const: got %0d expected 24480", d); n_fail++;
    end
    for (int word = 0; word < 2; word++) begin
      ahb_read(img_addr(word), d, w);
      n_tests++;
      if (d !== 32'h00FF_FFFF) begin
        $display("FAIL rearm_pair0_px%0d: got %h expected 00ffffff", word, d); n_fail++;
      end
    end
  endtask

  task automatic test_random_dims();
    logic [31:0] d;
    int w;
    ahb_write(32'(REG_WIDTH) * 4, 32'd4);
    ahb_write(32'(REG_HEIGHT) * 4, 32'd6);
    m_w = 4; m_h = 6;
    ahb_write(32'h7 * 4, 32'hFFFF_FFFF);
    ahb_read(32'h7 * 4, d, w);
    n_tests++;
    if (d !== 32'h0) begin
      $display("FAIL unmapped_reg7: got %h expected 0", d); n_fail++;
    end
    ahb_read(32'(REG_WIDTH) * 4, d, w);
    n_tests++;
    if (d !== 32'd4) begin
      $display("FAIL width_rw: got %h expected 4", d); n_fail++;
    end
    arm();
    send_beats(5, -1, 2);
    check_regs("rand_mid");
    send_beats(9, -1, 2);
    check_regs("rand_end");
    for (int word = 0; word < 24; word++) begin
      ahb_read(img_addr(word), d, w);
      n_tests++;
      if (d !== m_pixel(word)) begin
        $display("FAIL rand_img%0d: got %h expected %h", word, d, m_pixel(word)); n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int w;
    arm();
    send_beats(5, 0, 2);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    m_reset();
    check_regs("rst_mid");
    send_beats(3, 0, 2);
    check_regs("rst_idle_beats");
    ahb_read(32'(REG_WIDTH) * 4, d, w);
    n_tests++;
    if (d !== 32'd8) begin
      $display("FAIL rst_width: got %h expected 8", d); n_fail++;
    end
  endtask

  initial begin
    m_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    test_reset();
    test_capture();
    test_img_read();
    test_gaps_overrun();
    test_rearm();
    test_random_dims();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
